// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module   : des_pkg
// Brief    : DES S-box tables, chunk widths and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package des_pkg;

    localparam int c_CHUNK_IN  = 6;
    localparam int c_CHUNK_OUT = 4;
    localparam int c_NUM_SBOX  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Entry [s][{row,col}]; each 64-bit literal is one table row, column 0 in the top nibble.
    localparam logic [0:7][0:63][3:0] c_SBOX = {
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    // Row is the outer chunk bits, column the inner four.
    function automatic logic [3:0] f_sbox(input logic [2:0] idx, input logic [5:0] chunk);
        return c_SBOX[idx][{chunk[5], chunk[0], chunk[4:1]}];
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_sbox.sv
`default_nettype none
// ============================================================================
// Module   : des_sbox
// Brief    : Combinational lookup of one 6-bit chunk in DES S-box idx.
// Revision : 1.0 - initial release
// ============================================================================
module des_sbox
    import des_pkg::*;
(
    input  logic [2:0]             idx,
    input  logic [c_CHUNK_IN-1:0]  chunk,
    output logic [c_CHUNK_OUT-1:0] sval
);

    always_comb begin
        sval = f_sbox(idx, chunk);
    end

endmodule
`default_nettype wire

// File: rtl/des_sbox_layer.sv
`default_nettype none
// ============================================================================
// Module   : des_sbox_layer
// Brief    : Iterative DES substitution layer, LANES S-boxes per clock,
//            valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module des_sbox_layer
    import des_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] din,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] dout,
    output logic        busy
);

    localparam int c_ITER     = 8 / LANES;
    localparam int c_CNT_W    = (c_ITER > 1) ? $clog2(c_ITER) : 1;
    localparam int c_IN_STEP  = c_CHUNK_IN * LANES;
    localparam int c_OUT_STEP = c_CHUNK_OUT * LANES;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("des_sbox_layer: LANES must be 1, 2, 4 or 8");
    end

    state_t              r_state_q, w_state_d;
    logic [47:0]         r_sreg_q, w_sreg_d;
    logic [c_CNT_W-1:0]  r_cnt_q, w_cnt_d;
    logic [31:0]         r_acc_q, w_acc_d;
    logic [31:0]         r_dout_q, w_dout_d;
    logic                r_out_valid_q;
    logic                r_busy_q;

    logic                w_accept;
    logic                w_last;
    logic [2:0]          w_base;
    logic [c_OUT_STEP-1:0] w_lane_bits;
    logic [31:0]         w_acc_next;

    // Lane k handles S-box cnt*LANES+k on the k-th chunk from the top.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [2:0] w_idx;
        assign w_idx = w_base + 3'(k);
        des_sbox u_sbox (
            .idx   (w_idx),
            .chunk (r_sreg_q[47-c_CHUNK_IN*k -: c_CHUNK_IN]),
            .sval  (w_lane_bits[c_OUT_STEP-1-c_CHUNK_OUT*k -: c_CHUNK_OUT])
        );
    end

    assign in_ready  = (r_state_q == IDLE) || ((r_state_q == DONE) && out_ready);
    assign out_valid = r_out_valid_q;
    assign busy      = r_busy_q;
    assign dout      = r_dout_q;

    always_comb begin
        w_base     = 3'(32'(r_cnt_q) * LANES);
        w_last     = (r_cnt_q == c_CNT_W'(c_ITER - 1));
        w_acc_next = (r_acc_q << c_OUT_STEP) | 32'(w_lane_bits);
        w_accept   = in_valid && in_ready;

        w_state_d = r_state_q;
        w_sreg_d  = r_sreg_q;
        w_cnt_d   = r_cnt_q;
        w_acc_d   = r_acc_q;
        w_dout_d  = r_dout_q;

        case (r_state_q)
            IDLE: begin
                if (w_accept) begin
                    w_sreg_d  = din;
                    w_cnt_d   = '0;
                    w_state_d = PROC;
                end
            end
            PROC: begin
                w_sreg_d = r_sreg_q << c_IN_STEP;
                w_cnt_d  = r_cnt_q + c_CNT_W'(1);
                w_acc_d  = w_acc_next;
                // The accumulator has shifted a full 32 bits by now, so stale bits are gone.
                if (w_last) begin
                    w_dout_d  = w_acc_next;
                    w_state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        w_sreg_d  = din;
                        w_cnt_d   = '0;
                        w_state_d = PROC;
                    end else begin
                        w_state_d = IDLE;
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= IDLE;
            r_sreg_q      <= '0;
            r_cnt_q       <= '0;
            r_acc_q       <= '0;
            r_dout_q      <= '0;
            r_out_valid_q <= 1'b0;
            r_busy_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_sreg_q      <= w_sreg_d;
            r_cnt_q       <= w_cnt_d;
            r_acc_q       <= w_acc_d;
            r_dout_q      <= w_dout_d;
            r_out_valid_q <= (w_state_d == DONE);
            r_busy_q      <= (w_state_d == PROC);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_des_sbox_layer.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_sbox_layer
// Brief    : Directed bench for des_sbox_layer at LANES = 1, 2, 4 and 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_sbox_layer;

    localparam int c_NINST = 4;

    // Standard DES tables, one 16-nibble row per entry, S1 row 0 first.
    localparam logic [63:0] c_REF [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [c_NINST];
    logic [47:0] din       [c_NINST];
    logic        out_ready [c_NINST];
    logic        in_ready  [c_NINST];
    logic        out_valid [c_NINST];
    logic        busy      [c_NINST];
    logic [31:0] dout      [c_NINST];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < c_NINST; g++) begin : g_dut
        des_sbox_layer #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .din       (din[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .dout      (dout[g]),
            .busy      (busy[g])
        );
    end

    function automatic logic [31:0] ref_des(input logic [47:0] d);
        logic [31:0] r;
        logic [5:0]  c;
        logic [63:0] row_w;
        int          col;
        r = '0;
        for (int s = 0; s < 8; s++) begin
            c     = d[47-6*s -: 6];
            row_w = c_REF[s*4 + int'({c[5], c[0]})];
            col   = int'(c[4:1]);
            r[31-4*s -: 4] = row_w[(15-col)*4 +: 4];
        end
        return r;
    endfunction

    function automatic logic [47:0] next_din(input int k);
        logic [63:0] t;
        if (k < 64) begin
            t = {16'h0, {8{6'(k)}}};
        end else begin
            t = {$urandom(), $urandom()};
        end
        return t[47:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic stream(input int i, input int n);
        logic [47:0] q[$];
        logic [47:0] exp_d;
        int sent, got, cyc, last_cyc, gap_bad, limit, iter;
        bit acc;
        iter     = 8 >> i;
        sent     = 0;
        got      = 0;
        cyc      = 0;
        last_cyc = -1;
        gap_bad  = 0;
        limit    = n * (iter + 1) + 50;
        @(negedge clk);
        din[i]      = next_din(0);
        in_valid[i] = 1'b1;
        while (got < n && cyc < limit) begin
            if (out_valid[i]) begin
                chk($sformatf("L%0d_result_expected_%0d", 1 << i, got), q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    exp_d = q.pop_front();
                    chk($sformatf("L%0d_dout_%0d", 1 << i, got), dout[i], ref_des(exp_d));
                end
                got++;
                if (last_cyc >= 0 && cyc - last_cyc != iter + 1) gap_bad++;
                last_cyc = cyc;
            end
            acc = in_valid[i] && in_ready[i];
            if (acc) begin
                q.push_back(din[i]);
                sent++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (sent == n) in_valid[i] = 1'b0;
                else           din[i] = next_din(sent);
            end
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("L%0d_blocks_out", 1 << i), got, n);
        chk($sformatf("L%0d_blocks_in", 1 << i), sent, n);
        chk($sformatf("L%0d_leftover", 1 << i), q.size(), 0);
        chk($sformatf("L%0d_period_errs", 1 << i), gap_bad, 0);
    endtask

    initial begin
        int busy_cnt;
        int n;
        int seen;
        bit rdy_low;

        rst = 1'b1;
        for (int i = 0; i < c_NINST; i++) begin
            in_valid[i]  = 1'b0;
            din[i]       = '0;
            out_ready[i] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < c_NINST; i++) begin
            chk($sformatf("rst_in_ready_L%0d", 1 << i), in_ready[i], 1'b1);
            chk($sformatf("rst_out_valid_L%0d", 1 << i), out_valid[i], 1'b0);
            chk($sformatf("rst_busy_L%0d", 1 << i), busy[i], 1'b0);
            chk($sformatf("rst_dout_L%0d", 1 << i), dout[i], 32'h0);
        end
        rst = 1'b0;

        // LANES=8, all-zero block: result one cycle after acceptance.
        @(negedge clk);
        in_valid[3] = 1'b1;
        din[3]      = 48'h0;
        chk("l8_in_ready", in_ready[3], 1'b1);
        @(negedge clk);
        in_valid[3] = 1'b0;
        din[3]      = 48'hFFFF_FFFF_FFFF;
        chk("l8_busy", busy[3], 1'b1);
        chk("l8_not_yet_valid", out_valid[3], 1'b0);
        @(negedge clk);
        chk("l8_out_valid", out_valid[3], 1'b1);
        chk("l8_dout", dout[3], 32'hEFA72C4D);
        @(negedge clk);
        chk("l8_valid_one_cycle", out_valid[3], 1'b0);
        chk("l8_dout_held", dout[3], 32'hEFA72C4D);

        // LANES=1, all-ones block: eight busy cycles.
        in_valid[0] = 1'b1;
        din[0]      = 48'hFFFF_FFFF_FFFF;
        @(negedge clk);
        in_valid[0] = 1'b0;
        din[0]      = 48'h0;
        busy_cnt = 0;
        rdy_low  = 1'b1;
        n        = 0;
        while (!out_valid[0] && n < 20) begin
            if (busy[0]) busy_cnt++;
            if (in_ready[0]) rdy_low = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("l1_out_valid", out_valid[0], 1'b1);
        chk("l1_latency", n, 8);
        chk("l1_busy_cycles", busy_cnt, 8);
        chk("l1_in_ready_low", rdy_low, 1'b1);
        chk("l1_dout", dout[0], 32'hD9CE3DCB);

        for (int i = 0; i < c_NINST; i++) begin
            stream(i, 2000);
        end

        // LANES=2 back-pressure.
        @(negedge clk);
        out_ready[1] = 1'b0;
        in_valid[1]  = 1'b1;
        din[1]       = 48'h0123_4567_89AB;
        chk("bp_in_ready_idle", in_ready[1], 1'b1);
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        din[1]      = 48'h0;
        n = 0;
        while (!out_valid[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", out_valid[1], 1'b1);
        chk("bp_dout_a", dout[1], ref_des(48'h0123_4567_89AB));
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid[1], 1'b1);
            chk("bp_hold_dout", dout[1], ref_des(48'h0123_4567_89AB));
            chk("bp_hold_in_ready", in_ready[1], 1'b0);
        end
        in_valid[1]  = 1'b1;
        din[1]       = 48'hFEDC_BA98_7654;
        out_ready[1] = 1'b1;
        #1;
        chk("bp_in_ready_release", in_ready[1], 1'b1);
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        din[1]      = 48'h0;
        @(negedge clk);
        chk("bp_next_busy", busy[1], 1'b1);
        chk("bp_next_not_valid", out_valid[1], 1'b0);
        n = 0;
        while (!out_valid[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_second_valid", out_valid[1], 1'b1);
        chk("bp_dout_b", dout[1], ref_des(48'hFEDC_BA98_7654));

        // LANES=1, reset during the second PROC cycle.
        @(negedge clk);
        in_valid[0] = 1'b1;
        din[0]      = 48'hFFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid[0], 1'b0);
        chk("mid_rst_in_ready", in_ready[0], 1'b1);
        chk("mid_rst_dout", dout[0], 32'h0);
        chk("mid_rst_busy", busy[0], 1'b0);
        rst  = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid[0]) seen++;
        end
        chk("mid_rst_no_partial", seen, 0);
        in_valid[0] = 1'b1;
        din[0]      = 48'h0;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        din[0]      = 48'hFFFF_FFFF_FFFF;
        n = 0;
        while (!out_valid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("post_rst_valid", out_valid[0], 1'b1);
        chk("post_rst_dout", dout[0], 32'hEFA72C4D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
